reg_bank16x32: RTL and testbench

//  16-entry x 32-bit register bank feeding the 16:1 word/flag selectors downstream.

---
 rtl/reg_bank16x32_pkg.sv | 27 ++
 rtl/reg_entry32.sv | 30 +++
 rtl/reg_bank16x32.sv | 100 ++++++++++
 tb/tb_reg_bank16x32.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank16x32_pkg.sv
// Shared definitions for the 16x32 register bank: sizes, FSM encoding and the
// entry-slice macro that keeps bus ordering aligned with the 16:1 selectors.

// Top bit of entry k inside the flattened 512-bit bank bus (entry 0 in the MSBs).
`define RB_ENTRY_HI(k) (511 - 32 * (k))

package reg_bank16x32_pkg;

  localparam int N_ENTRIES = 16;
  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 5;

  // Width of the clear-sweep counter: one count per entry.
  localparam int CTR_W     = 4;

  // Bank controller state.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Address is in range when it names one of the 16 entries.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(N_ENTRIES));
  endfunction

endpackage

// File: rtl/reg_entry32.sv
// One bank entry: a 32-bit data register plus its written flag.
// clr wins over wr_en; the controller never raises both in the same cycle.

module reg_entry32
  import reg_bank16x32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Entry storage: cleared by reset or a sweep, loaded by an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank16x32.sv
// 16-entry x 32-bit register bank with a valid/ready write port, a flattened
// 512-bit read bus, a per-entry valid vector and a one-entry-per-cycle clear.
//
// Write handshake: a write is taken on a rising clk edge where wr_valid and
// wr_ready are both 1; the requester keeps wr_addr/wr_data stable until then.
// wr_ready is low during reset, during the clear sweep, and in any cycle where
// clr_req is raised, so a write never races the start of a sweep.

module reg_bank16x32
  import reg_bank16x32_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         clr_req,
  output logic                         busy,
  output logic                         wr_err,
  output logic [N_ENTRIES*WIDTH-1:0]   bank_out,
  output logic [N_ENTRIES-1:0]         valid_out
);

  state_t             state;
  logic [CTR_W-1:0]   clr_ctr;
  logic               wr_fire;
  logic               addr_ok;
  logic [N_ENTRIES-1:0] entry_wr_en;
  logic [N_ENTRIES-1:0] entry_clr;
  logic [WIDTH-1:0]     entry_data  [N_ENTRIES];
  logic [N_ENTRIES-1:0] entry_valid;

  // Ready only while idle and not being asked to start a sweep this cycle.
  always_comb begin
    wr_ready = !rst && (state == ST_IDLE) && !clr_req;
    wr_fire  = wr_valid && wr_ready;
    addr_ok  = addr_in_range(wr_addr);
  end

  // Bank controller: IDLE waits for clr_req; CLEAR walks clr_ctr 0..15 once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_ctr <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_ctr <= '0;
            busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_ctr <= clr_ctr + CTR_W'(1);
          if (clr_ctr == CTR_W'(N_ENTRIES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range writes complete the handshake but only raise a one-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_fire && !addr_ok;
    end
  end

  // Per-entry write enables and sweep clears, plus the entry registers.
  for (genvar k = 0; k < N_ENTRIES; k++) begin : g_entry
    assign entry_wr_en[k] = wr_fire && addr_ok && (wr_addr[CTR_W-1:0] == CTR_W'(k));
    assign entry_clr[k]   = (state == ST_CLEAR) && (clr_ctr == CTR_W'(k));

    reg_entry32 u_entry (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (entry_wr_en[k]),
      .clr     (entry_clr[k]),
      .wr_data (wr_data),
      .data    (entry_data[k]),
      .valid   (entry_valid[k])
    );

    // Entry 0 sits in the MSBs of both buses to match the selector ordering.
    assign bank_out[`RB_ENTRY_HI(k) -: WIDTH] = entry_data[k];
    assign valid_out[N_ENTRIES-1-k]           = entry_valid[k];
  end

endmodule

// File: tb/tb_reg_bank16x32.sv
// Bench for reg_bank16x32: directed scenarios plus randomized writes, checked
// against an array model of the sixteen entries.

module tb_reg_bank16x32;

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         clr_req;
  logic         busy;
  logic         wr_err;
  logic [511:0] bank_out;
  logic [15:0]  valid_out;

  int n_cmp;
  int n_bad;

  // Reference model: entry contents and written flags.
  logic [31:0] mdl_data  [16];
  logic        mdl_valid [16];

  reg_bank16x32 dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .busy      (busy),
    .wr_err    (wr_err),
    .bank_out  (bank_out),
    .valid_out (valid_out)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected flat bus: entries concatenated in order, entry 0 ending up in the MSBs.
  function automatic logic [511:0] exp_bank();
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b = (b << 32) | {480'd0, mdl_data[k]};
    return b;
  endfunction

  function automatic logic [15:0] exp_valid();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v = (v << 1) | {15'd0, mdl_valid[k]};
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      mdl_data[k]  = '0;
      mdl_valid[k] = 1'b0;
    end
  endtask

  // Drive one write and wait (bounded) for acceptance; updates the model. Returns accepted flag.
  task automatic drive_write(input logic [4:0] a, input logic [31:0] d, output logic ok);
    logic seen;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      seen = wr_ready;
      step();
      ok = seen;
    end
    wr_valid = 1'b0;
    if (ok && a < 5'd16) begin
      mdl_data[a[3:0]]  = d;
      mdl_valid[a[3:0]] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    model_clear();
    #13;
    n_cmp++;
    if (bank_out !== 512'd0) begin n_bad++; $display("FAIL reset_bank got %h want 0", bank_out); end
    n_cmp++;
    if (valid_out !== 16'h0 || busy !== 1'b0 || wr_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got valid=%h busy=%b err=%b want 0/0/0", valid_out, busy, wr_err);
    end
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", wr_ready); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got %b want 1", wr_ready); end
  endtask

  task automatic test_single_write();
    logic ok;
    drive_write(5'd0, 32'hDEADBEEF, ok);
    n_cmp++;
    if (!ok || bank_out[511:480] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL write0_data got %h want deadbeef (accepted=%b)", bank_out[511:480], ok);
    end
    n_cmp++;
    if (valid_out !== 16'h8000) begin n_bad++; $display("FAIL write0_valid got %h want 8000", valid_out); end
    n_cmp++;
    if (wr_err !== 1'b0) begin n_bad++; $display("FAIL write0_err got %b want 0", wr_err); end
  endtask

  task automatic test_overwrite();
    logic ok;
    drive_write(5'd15, 32'h12345678, ok);
    drive_write(5'd15, 32'hCAFEF00D, ok);
    n_cmp++;
    if (bank_out[31:0] !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL overwrite15 got %h want cafef00d", bank_out[31:0]);
    end
    n_cmp++;
    if (valid_out !== exp_valid() || valid_out[0] !== 1'b1) begin
      n_bad++; $display("FAIL overwrite15_valid got %h want %h", valid_out, exp_valid());
    end
  endtask

  // Back-to-back randomized writes: wr_valid held high, a new request every cycle.
  task automatic test_back_to_back();
    logic [4:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 48; i++) begin
      a = 5'($urandom_range(0, 3) == 0 ? $urandom_range(16, 31) : $urandom_range(0, 15));
      d = $urandom;
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      n_cmp++;
      if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, wr_ready); end
      step();
      if (a < 5'd16) begin
        mdl_data[a[3:0]]  = d;
        mdl_valid[a[3:0]] = 1'b1;
      end
      n_cmp++;
      if (bank_out !== exp_bank() || valid_out !== exp_valid()) begin
        n_bad++; $display("FAIL b2b_state[%0d] addr=%0d got valid=%h want %h", i, a, valid_out, exp_valid());
      end
      n_cmp++;
      if (wr_err !== (a >= 5'd16)) begin
        n_bad++; $display("FAIL b2b_err[%0d] addr=%0d got %b want %b", i, a, wr_err, (a >= 5'd16));
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic fill_k();
    logic ok;
    for (int k = 0; k < 16; k++) drive_write(5'(k), 32'(k), ok);
  endtask

  task automatic test_clear();
    int cnt;
    fill_k();
    n_cmp++;
    if (bank_out !== exp_bank() || valid_out !== 16'hFFFF) begin
      n_bad++; $display("FAIL fill_all got valid=%h want ffff", valid_out);
    end
    clr_req = 1'b1;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_req_blocks got %b want 0", wr_ready); end
    step();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      n_cmp++;
      if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clear_ready[%0d] got %b want 0", cnt, wr_ready); end
      step();
    end
    model_clear();
    n_cmp++;
    if (cnt != 16) begin n_bad++; $display("FAIL clear_busy_cycles got %0d want 16", cnt); end
    n_cmp++;
    if (bank_out !== 512'd0 || valid_out !== 16'h0) begin
      n_bad++; $display("FAIL clear_result got valid=%h want 0000", valid_out);
    end
  endtask

  task automatic test_hold_across_clear();
    logic        ok;
    int          cnt;
    logic [31:0] d;
    d = $urandom;
    drive_write(5'd3, 32'h33333333, ok);
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = d; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      n_cmp++;
      if (bank_out[415:384] === d && d != 32'd0) begin
        n_bad++; $display("FAIL hold_early_write[%0d] got %h want not yet written", cnt, bank_out[415:384]);
      end
      step();
    end
    model_clear();
    n_cmp++;
    if (wr_ready !== 1'b1 || valid_out !== 16'h0) begin
      n_bad++; $display("FAIL hold_after_busy got ready=%b valid=%h want 1/0000", wr_ready, valid_out);
    end
    step();
    wr_valid = 1'b0;
    mdl_data[3] = d; mdl_valid[3] = 1'b1;
    n_cmp++;
    if (bank_out !== exp_bank() || valid_out !== 16'h1000) begin
      n_bad++; $display("FAIL hold_write3 got %h valid=%h want %h valid=1000", bank_out[415:384], valid_out, d);
    end
  endtask

  task automatic test_bad_addr();
    logic ok;
    logic [511:0] b0;
    logic [15:0]  v0;
    drive_write(5'd9, 32'hA5A5_0009, ok);
    b0 = exp_bank(); v0 = exp_valid();
    drive_write(5'd20, 32'hFFFF_FFFF, ok);
    n_cmp++;
    if (!ok || wr_err !== 1'b1) begin n_bad++; $display("FAIL bad_addr_err got %b (accepted=%b) want 1", wr_err, ok); end
    n_cmp++;
    if (bank_out !== b0 || valid_out !== v0) begin
      n_bad++; $display("FAIL bad_addr_unchanged got valid=%h want %h", valid_out, v0);
    end
    step();
    n_cmp++;
    if (wr_err !== 1'b0) begin n_bad++; $display("FAIL bad_addr_pulse got %b want 0", wr_err); end
  endtask

  task automatic test_reset_mid_clear();
    logic ok;
    int   cnt;
    fill_k();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 7) begin cnt++; step(); end
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    n_cmp++;
    if (bank_out !== 512'd0 || valid_out !== 16'h0) begin
      n_bad++; $display("FAIL midclr_rst_bank got valid=%h want 0000", valid_out);
    end
    n_cmp++;
    if (busy !== 1'b0 || wr_ready !== 1'b0 || wr_err !== 1'b0) begin
      n_bad++; $display("FAIL midclr_rst_flags got busy=%b ready=%b err=%b want 0/0/0", busy, wr_ready, wr_err);
    end
    step();
    rst = 1'b0;
    #1;
    drive_write(5'd2, 32'h0BAD_F00D, ok);
    n_cmp++;
    if (!ok || bank_out !== exp_bank() || valid_out !== 16'h2000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midclr_write2 got %h valid=%h busy=%b want 0badf00d valid=2000 busy=0",
                        bank_out[447:416], valid_out, busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_write();
    test_overwrite();
    test_back_to_back();
    test_clear();
    test_hold_across_clear();
    test_bad_addr();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
